// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES128 job arbiter slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package aes128_pkg;

  localparam int AES_BLOCK_W = 128;

  // Watchdog counter width; covers the full legal TIMEOUT_CYCLES range (2..255).
  localparam int WDOG_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/aes128_rr_arbiter2.sv
// Two-way round-robin grant: picks the only valid requester, or rr_ptr when both are valid.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own accept condition.
// Ports: i_valid0/i_valid1 request flags, i_rr_ptr preferred index on contention,
//        o_grant granted index, o_any at least one requester valid.
module aes128_rr_arbiter2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_rr_ptr,
  output logic o_grant,
  output logic o_any
);

  always_comb begin
    o_any   = i_valid0 | i_valid1;
    o_grant = 1'b0;
    if (i_valid0 && i_valid1) begin
      o_grant = i_rr_ptr;
    end else if (i_valid1) begin
      o_grant = 1'b1;
    end
  end

endmodule

// File: rtl/aes128_job_arbiter.sv
// Shares one AES128 core between two requesters; round-robin accept, tagged result, watchdog abort.
// Latency: core_start 1 cycle after accept, result 1 cycle after core_done (or T+2+TIMEOUT_CYCLES on abort).
// Backpressure: result held in RESP until res_ready; no job accepted outside IDLE.
// Ports: clk/rst (sync, active high); req0_*/req1_* valid/ready job inputs with data+key;
//        core_* drive and observe the AES core; res_* tagged result with valid/ready; busy = not IDLE.
module aes128_job_arbiter
  import aes128_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [AES_BLOCK_W-1:0] req0_data,
  input  logic [AES_BLOCK_W-1:0] req0_key,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [AES_BLOCK_W-1:0] req1_data,
  input  logic [AES_BLOCK_W-1:0] req1_key,
  output logic                   core_start,
  output logic [AES_BLOCK_W-1:0] core_datain,
  output logic [AES_BLOCK_W-1:0] core_cipherkey,
  input  logic [AES_BLOCK_W-1:0] core_dataout,
  input  logic                   core_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [AES_BLOCK_W-1:0] res_data,
  output logic                   res_src,
  output logic                   res_err,
  output logic                   busy
);

  localparam logic [WDOG_W-1:0] LP_WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  arb_state_t             r_state;
  arb_state_t             w_next_state;
  logic                   r_rr_ptr;
  logic [WDOG_W-1:0]      r_wdog;
  logic [AES_BLOCK_W-1:0] r_job_data;
  logic [AES_BLOCK_W-1:0] r_job_key;
  logic                   r_job_src;
  logic [AES_BLOCK_W-1:0] r_res_data;
  logic                   r_res_err;

  logic w_grant;
  logic w_any;
  logic w_accept;
  logic w_timeout;

  aes128_rr_arbiter2 u_rr (
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );

  // In IDLE the granted requester is always ready, so any valid request is a handshake.
  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_timeout = (r_wdog == LP_WDOG_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next_state = LAUNCH;
      LAUNCH:  w_next_state = BUSY;
      BUSY:    if (core_done || w_timeout) w_next_state = RESP;
      RESP:    if (res_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    core_start = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = req0_valid && (w_grant == 1'b0);
        req1_ready = req1_valid && (w_grant == 1'b1);
      end
      LAUNCH:  core_start = 1'b1;
      BUSY:    ;
      RESP:    res_valid = 1'b1;
      default: ;
    endcase
  end

  // Job, arbitration pointer and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= 1'b0;
      r_wdog     <= '0;
      r_job_data <= '0;
      r_job_key  <= '0;
      r_job_src  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_job_data <= w_grant ? req1_data : req0_data;
        r_job_key  <= w_grant ? req1_key  : req0_key;
        r_job_src  <= w_grant;
        // Last winner drops to lowest priority.
        r_rr_ptr   <= ~w_grant;
      end
      if (r_state == LAUNCH) begin
        r_wdog <= '0;
      end else if (r_state == BUSY) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  // Result capture; core_done takes priority over a coincident timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else if (r_state == BUSY) begin
      if (core_done) begin
        r_res_data <= core_dataout;
        r_res_err  <= 1'b0;
      end else if (w_timeout) begin
        r_res_data <= '0;
        r_res_err  <= 1'b1;
      end
    end
  end

  assign core_datain    = r_job_data;
  assign core_cipherkey = r_job_key;
  assign res_data       = r_res_data;
  assign res_src        = r_job_src;
  assign res_err        = r_res_err;

endmodule

// File: doc/aes128_job_arbiter.md
# aes128_job_arbiter

Shares one AES128 encryption core between two independent requesters. The block accepts a plaintext/key job from either port using round-robin arbitration, launches the core, and holds the core inputs stable for the whole encryption. It then returns the ciphertext on a single result port, tagged with the source requester. A watchdog flags a core that never completes. The block sits directly above the AES128 top-level core and drives its `start`, `datain` and `cipherkey` inputs.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64. Number of BUSY cycles without `core_done` before the job is aborted with an error. Legal range 2..255.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester has a job.
- `req0_ready` / `req1_ready`  out  1  job accepted this cycle.
- `req0_data` / `req1_data`  in  128  plaintext block.
- `req0_key` / `req1_key`  in  128  cipher key.
- `core_start`  out  1  one-cycle launch pulse to the core.
- `core_datain`  out  128  registered plaintext to the core.
- `core_cipherkey`  out  128  registered key to the core.
- `core_dataout`  in  128  ciphertext from the core.
- `core_done`  in  1  core completion; sampled only in BUSY.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes result.
- `res_data`  out  128  ciphertext, or all zeros on error.
- `res_src`  out  1  requester index of the result.
- `res_err`  out  1  job aborted by the watchdog.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE → LAUNCH → BUSY → RESP → IDLE.
- IDLE:
  - Grant: the only valid requester; if both are valid, the requester selected by `rr_ptr`.
  - `reqN_ready` is asserted combinationally, only for the granted N and only when `reqN_valid` is high.
  - On a handshake: latch data, key and source into job registers, then go to LAUNCH.
  - `rr_ptr` ← the other index, so the last winner gets lowest priority.
- LAUNCH:
  - `core_start` = 1 for exactly this cycle.
  - Clear the watchdog counter; go to BUSY.
- BUSY:
  - Counter increments every cycle.
  - If `core_done` = 1: capture `core_dataout` into `res_data`, set `res_err` = 0, go to RESP.
  - Else if counter = `TIMEOUT_CYCLES`-1: set `res_data` = 0, `res_err` = 1, go to RESP.
  - If `core_done` and the timeout fall in the same cycle, `core_done` wins.
- RESP:
  - `res_valid` = 1; `res_data`, `res_src` and `res_err` are held stable.
  - When `res_valid && res_ready`, go to IDLE. No new job is accepted in that same cycle.
- `core_datain` and `core_cipherkey` are driven from the job registers and are stable from LAUNCH through RESP.
- `core_done` is ignored in IDLE, LAUNCH and RESP, so a late `done` after a timeout is dropped.
- Requesters must hold `valid` and payload stable until `ready`. The block never accepts from both ports in one cycle.
- No assumption is made about `req*_valid` being deasserted after a handshake.

## Timing
- Reset values:
  - State IDLE, `rr_ptr` = 0, counter = 0.
  - `core_start` = 0, `core_datain` = 0, `core_cipherkey` = 0.
  - `res_valid` = 0, `res_data` = 0, `res_src` = 0, `res_err` = 0, `busy` = 0.
  - `req*_ready` = 0.
- Reset mid-job returns to IDLE immediately; the pending result is discarded.
- Latency for a handshake at cycle T:
  - `core_start` at T+1.
  - BUSY from T+2.
  - `core_done` sampled at cycle D ≥ T+2 gives `res_valid` at D+1.
- Timeout result: `res_valid` at T+2+`TIMEOUT_CYCLES`.
- Minimum job-to-job spacing: the next accept is one cycle after the result handshake.

## Structure
- Shared package `aes128_pkg`:
  - `AES_BLOCK_W` = 128.
  - State enum `arb_state_t` {IDLE, LAUNCH, BUSY, RESP}.
  - Watchdog counter width constant (8 bits).
- Sub-module `aes128_rr_arbiter2`: combinational two-way round-robin grant from the two `valid` inputs plus `rr_ptr`, producing a grant index and an any-grant flag.
- The arbiter instantiates `aes128_rr_arbiter2`; the core itself is instantiated by the integrating top, not by this block.

## Test plan
- Single job on port 0 (key 000102…0F, data 00112233…FF); model core asserts done 10 cycles after start. Required:
  - `core_start` one cycle after accept.
  - `res_valid` with `res_data` = 69C4E0D8…C55A, `res_src` = 0, `res_err` = 0.
- Both ports valid continuously for 4 jobs. Required:
  - Grants alternate 0,1,0,1 starting from port 0 after reset.
  - `res_src` matches each grant.
- `res_ready` held low for 5 cycles in RESP. Required:
  - `res_*` stable throughout.
  - Both `req*_ready` stay 0.
  - Return to IDLE on the cycle after the handshake.
- Core never asserts done, `TIMEOUT_CYCLES` = 8. Required:
  - `res_err` = 1 and `res_data` = 0 at accept+10.
  - A `core_done` pulse injected afterwards does not change `res_*`.
- `rst` asserted for one cycle in the middle of BUSY. Required:
  - Next cycle all outputs are at reset values and `rr_ptr` = 0.
  - A fresh job then completes normally.
- `core_done` in the same cycle as the timeout. Required: `res_err` = 0 and the result is the captured `core_dataout`.
